// File: rtl/fifo_pkg.sv
// Shared sizing defaults and reset threshold values for the status FIFO.
package fifo_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 3;
  localparam int FIFO_DEPTH = 2 ** ADDR_W_DEF;
  localparam int AE_RST_DEF = 1;

  function automatic int depth_of(input int addr_w);
    return 2 ** addr_w;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one write port, one registered read port; the
// array itself is never reset, only the read register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [depth_of(ADDR_W)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rdata <= '0;
    else if (clear)  rdata <= '0;
    else if (re)     rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_status.sv
// Synchronous FIFO with occupancy count, programmable almost-full/empty
// thresholds and sticky overflow/underflow flags for the flow-control FSM.
module fifo_status
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W:0]   umbral_af,
  input  logic [ADDR_W:0]   umbral_ae,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty_Fifo,
  output logic              no_empty_Fifo,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              Fifo_overflow,
  output logic              Fifo_underflow,
  output logic [ADDR_W:0]   count
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH  = CNT_W'(depth_of(ADDR_W));
  localparam logic [ADDR_W:0] AF_RST = CNT_W'(depth_of(ADDR_W) - 1);
  localparam logic [ADDR_W:0] AE_RST = CNT_W'(AE_RST_DEF);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   af_q, ae_q;
  logic              full, empty, push_ok, pop_ok;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  // A pop frees the slot a same-cycle push needs, so full+push+pop is legal.
  assign pop_ok  = pop && !empty && !init;
  assign push_ok = push && (!full || pop_ok) && !init;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      af_q           <= AF_RST;
      ae_q           <= AE_RST;
      valid_out      <= 1'b0;
      Fifo_overflow  <= 1'b0;
      Fifo_underflow <= 1'b0;
    end else if (init) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      af_q           <= umbral_af;
      ae_q           <= umbral_ae;
      valid_out      <= 1'b0;
      Fifo_overflow  <= 1'b0;
      Fifo_underflow <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !pop && full) Fifo_overflow  <= 1'b1;
      if (pop && empty)         Fifo_underflow <= 1'b1;
    end
  end

  assign empty_Fifo    = empty;
  assign no_empty_Fifo = !empty;
  assign almost_full   = (count >= af_q);
  assign almost_empty  = (count <= ae_q);

  fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .reset (reset),
    .clear (init),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (data_out)
  );
endmodule
